instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the LITE-16 core. Owns the PC and fetches 16-bit instruction words over a req/ack memory port.
//  Holds each fetched word and presents it, split into nibble fields and decode flags, to the register fetch unit.
//  Accepts a redirect (taken jump/call) from execute and flushes any wrong-path fetch.
// PARAMETERS
//  RESET_PC   16'h0000   PC loaded on reset (word address)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  16  word address of request; stable while imem_req=1
//  imem_ack     in   1   memory response valid this cycle; only meaningful while imem_req=1
//  imem_rdata   in   16  instruction word, sampled on imem_ack
//  redirect     in   1   execute has a taken jmp/call; pulse, one cycle
//  redirect_pc  in   16  target PC, valid with redirect
//  inst_ready   in   1   downstream consumes the held instruction this cycle
//  inst_valid   out  1   held instruction valid
//  inst_pc      out  16  address of the held instruction
//  opcode       out  4   instr[3:0]
//  i4_7         out  4   instr[7:4]
//  i8_11        out  4   instr[11:8]
//  i12_15       out  4   instr[15:12]
//  ri, st, jmp, fn  out  1 each  decode flags for the register fetch unit
// BEHAVIOUR
//  - Clock and reset: one clock, clk. rst is synchronous and active-high.
//  - Reset: pc=RESET_PC, state=FETCH, flush=0, imem_req=0, inst_valid=0.
//    All field and flag outputs and inst_pc are 0. A reset mid-handshake abandons the transaction.
//  - FSM states: FETCH, FLUSH, HOLD.
//  - FETCH:
//    - imem_req=1, imem_addr=pc.
//    - On imem_ack: latch IR<=imem_rdata and inst_pc<=pc; pc<=pc+1 (16-bit wrap, FFFF->0000); go to HOLD.
//    - The ack may arrive in the first request cycle.
//  - HOLD:
//    - inst_valid=1; imem_req=0. IR and all outputs stay stable until accepted.
//    - inst_valid & inst_ready: next state FETCH, inst_valid=0 next cycle.
//    - Throughput is 1 instruction per 2 cycles with a zero-wait memory.
//  - Redirect (priority over ready and ack):
//    - In HOLD: drop the held word (inst_valid=0 next cycle), pc<=redirect_pc, go to FETCH.
//    - In FETCH with imem_ack the same cycle: discard rdata, pc<=redirect_pc, stay in FETCH.
//    - In FETCH without ack: pc<=redirect_pc, go to FLUSH. Keep imem_req=1 and imem_addr at the old address;
//      the handshake is never withdrawn.
//    - FLUSH: on imem_ack, discard rdata and go to FETCH (now using the new pc).
//    - Redirect again in FLUSH: pc<=newest target, stay in FLUSH.
//  - Field/flag outputs are registered and derived from IR only; they are never combinational from imem_rdata.
//  - Decode, opcode -> flags:
//    - 0x0-0x7 reg ALU: ri=0 st=0 jmp=0 fn=0
//    - 0x8-0xB imm ALU: ri=1
//    - 0xC ST: st=1
//    - 0xD LD: all flags 0
//    - 0xE JMP: jmp=1 fn=0
//    - 0xF CALL: jmp=1 fn=1 (link written to i8_11)
//  - inst_ready while inst_valid=0 is ignored.
// STRUCTURE
//  - Shared include lite16_defs.vh:
//    - opcode localparams OP_ST=4'hC, OP_LD=4'hD, OP_JMP=4'hE, OP_CALL=4'hF, OP_IMM_LO=4'h8, OP_IMM_HI=4'hB
//    - state encodings S_FETCH, S_FLUSH, S_HOLD
//  - Sub-module instruction_decoder: purely combinational, opcode -> {ri,st,jmp,fn}.
//    Its output is registered into the flag outputs at IR load.
// TESTING
//  1. Reset, RESET_PC=0, mem[0]=16'h3218, ack 1 cycle after req, ready=1:
//     -> HOLD with opcode=8, i4_7=1, i8_11=2, i12_15=3, ri=1, inst_pc=0; next imem_addr=1.
//  2. Wait states: ack delayed 3 cycles:
//     -> imem_req and imem_addr held constant all 4 cycles; IR loads only on the ack cycle.
//  3. Backpressure: inst_ready=0 for 5 cycles in HOLD:
//     -> outputs stable, imem_req=0; ready=1 -> inst_valid=0 next cycle.
//  4. Redirect in FETCH without ack (addr 5, target 16'h0040), ack 2 cycles later:
//     -> req stays at 5, rdata discarded, inst_valid never set; next request at 0x0040.
//  5. Redirect and ack in the same cycle, and redirect in HOLD:
//     -> no instruction presented; next imem_addr = target.
//  6. Wrap and decode: pc=16'hFFFF, word 16'h000F:
//     -> jmp=1, fn=1; next imem_addr=16'h0000. Assert rst mid-FLUSH -> req=0, state FETCH at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the LITE-16 instruction fetch unit: opcode
// constants, fetch FSM state encoding and a small decode helper.
package instruction_fetch_unit_pkg;

    localparam logic [3:0] OP_IMM_LO = 4'h8;
    localparam logic [3:0] OP_IMM_HI = 4'hB;
    localparam logic [3:0] OP_ST     = 4'hC;
    localparam logic [3:0] OP_LD     = 4'hD;
    localparam logic [3:0] OP_JMP    = 4'hE;
    localparam logic [3:0] OP_CALL   = 4'hF;

    // FETCH: request outstanding for pc, FLUSH: wrong-path request still
    // outstanding, HOLD: instruction word presented downstream
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // True for the immediate-operand ALU opcode range
    function automatic logic isImmOp(input logic [3:0] op);
        return (op >= OP_IMM_LO) && (op <= OP_IMM_HI);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_decoder.sv
// Purely combinational opcode decoder producing the register-fetch flags.
// The fetch unit registers these flags at the same time it loads IR.
module instruction_decoder
    import instruction_fetch_unit_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       ri_o,
    output logic       st_o,
    output logic       jmp_o,
    output logic       fn_o
);

    // Map opcode to flags; register ALU ops and loads leave all flags clear
    always_comb begin
        ri_o  = 1'b0;
        st_o  = 1'b0;
        jmp_o = 1'b0;
        fn_o  = 1'b0;
        if (isImmOp(opcode_i)) begin
            ri_o = 1'b1;
        end
        case (opcode_i)
            OP_ST:   st_o = 1'b1;
            OP_LD:   begin end
            OP_JMP:  jmp_o = 1'b1;
            OP_CALL: begin
                jmp_o = 1'b1;
                fn_o  = 1'b1;
            end
            default: begin end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LITE-16 front end: owns the PC, fetches instruction words over a req/ack
// memory port, holds each word for the register fetch unit and handles
// redirects from execute, including flushing a wrong-path fetch that the
// memory has already accepted.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [15:0] inst_pc,
    output logic [3:0]  opcode,
    output logic [3:0]  i4_7,
    output logic [3:0]  i8_11,
    output logic [3:0]  i12_15,
    output logic        ri,
    output logic        st,
    output logic        jmp,
    output logic        fn
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] reqAddr_q, reqAddr_d;
    logic [15:0] ir_q;
    logic [15:0] instPc_q;
    logic [3:0]  flags_q;
    logic        loadIr;
    logic        decRi, decSt, decJmp, decFn;

    instruction_decoder u_decoder (
        .opcode_i (imem_rdata[3:0]),
        .ri_o     (decRi),
        .st_o     (decSt),
        .jmp_o    (decJmp),
        .fn_o     (decFn)
    );

    // Next-state logic; redirect takes priority over both ack and ready
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        reqAddr_d = reqAddr_q;
        loadIr    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem_ack) begin
                        state_d   = S_FLUSH;
                        reqAddr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    loadIr  = 1'b1;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (inst_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // FSM, PC and in-flight request address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            reqAddr_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            reqAddr_q <= reqAddr_d;
        end
    end

    // Instruction register, its address and decode flags, loaded together
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= 16'h0000;
            instPc_q <= 16'h0000;
            flags_q  <= 4'h0;
        end else if (loadIr) begin
            ir_q     <= imem_rdata;
            instPc_q <= pc_q;
            flags_q  <= {decRi, decSt, decJmp, decFn};
        end
    end

    // Request stays up in FLUSH at the old address so the handshake is never
    // withdrawn; reset drops it immediately to abandon a pending transaction
    always_comb begin
        imem_req   = !rst && (state_q != S_HOLD);
        imem_addr  = (state_q == S_FLUSH) ? reqAddr_q : pc_q;
        inst_valid = !rst && (state_q == S_HOLD);
    end

    assign inst_pc = instPc_q;
    assign opcode  = ir_q[3:0];
    assign i4_7    = ir_q[7:4];
    assign i8_11   = ir_q[11:8];
    assign i12_15  = ir_q[15:12];
    assign ri      = flags_q[3];
    assign st      = flags_q[2];
    assign jmp     = flags_q[1];
    assign fn      = flags_q[0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. Expected {pc, word} pairs
// are pushed when an accepted ack is driven and popped when HOLD is seen.
module tb_instruction_fetch_unit;

    localparam logic [15:0] RESET_PC_TB = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [3:0]  opcode, i4_7, i8_11, i12_15;
    logic        ri, st, jmp, fn;

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] expQ[$];

    instruction_fetch_unit #(.RESET_PC(RESET_PC_TB)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .i4_7        (i4_7),
        .i8_11       (i8_11),
        .i12_15      (i12_15),
        .ri          (ri),
        .st          (st),
        .jmp         (jmp),
        .fn          (fn)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode table: {ri, st, jmp, fn}
    function automatic logic [3:0] expFlags(input logic [3:0] op);
        case (op)
            4'h8, 4'h9, 4'hA, 4'hB: return 4'b1000;
            4'hC:                   return 4'b0100;
            4'hE:                   return 4'b0010;
            4'hF:                   return 4'b0011;
            default:                return 4'b0000;
        endcase
    endfunction

    // Observed presentation: {valid, pc, word, flags}
    function automatic logic [36:0] obsVec();
        return {inst_valid, inst_pc, i12_15, i8_11, i4_7, opcode, ri, st, jmp, fn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000; redirect = 1'b0;
        redirect_pc = 16'h0000; inst_ready = 1'b1;
        step();
        step();
        checkCount++;
        if ({imem_req, obsVec()} !== 38'h0) begin
            $display("[TB] FAIL reset_state got %h want 0", {imem_req, obsVec()});
        end else passCount++;
        rst = 1'b0;
        step();
        checkCount++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC_TB}) begin
            $display("[TB] FAIL reset_first_req got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC_TB);
        end else passCount++;
    endtask

    task automatic test_basic_fetch();
        logic [31:0] e;
        imem_ack = 1'b1; imem_rdata = 16'h3218;
        expQ.push_back({16'h0000, 16'h3218});
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
            $display("[TB] FAIL basic_hold got %h want %h", obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
        end else passCount++;
        step();
        checkCount++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0001}) begin
            $display("[TB] FAIL basic_next got v%b r%b a%h want v0 r1 a0001", inst_valid, imem_req, imem_addr);
        end else passCount++;
    endtask

    task automatic test_wait_states();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if ({imem_req, imem_addr, inst_valid, i12_15, i8_11, i4_7, opcode} !== {1'b1, 16'h0001, 1'b0, 16'h3218}) begin
                $display("[TB] FAIL wait_hold cyc%0d got r%b a%h v%b ir%h want r1 a0001 v0 ir3218",
                         i, imem_req, imem_addr, inst_valid, {i12_15, i8_11, i4_7, opcode});
            end else passCount++;
            if (i < 3) step();
        end
        imem_ack = 1'b1; imem_rdata = 16'hA5C1;
        expQ.push_back({16'h0001, 16'hA5C1});
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
            $display("[TB] FAIL wait_load got %h want %h", obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
        end else passCount++;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        inst_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h7B2C;
        expQ.push_back({16'h0002, 16'h7B2C});
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if ({imem_req, obsVec()} !== {1'b0, 1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
                $display("[TB] FAIL bp_stable cyc%0d got %h want %h", i, {imem_req, obsVec()},
                         {1'b0, 1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
            end else passCount++;
            if (i < 4) step();
        end
        inst_ready = 1'b1;
        step();
        checkCount++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0003}) begin
            $display("[TB] FAIL bp_release got v%b r%b a%h want v0 r1 a0003", inst_valid, imem_req, imem_addr);
        end else passCount++;
    endtask

    task automatic test_redirect_fetch();
        logic [31:0] e;
        logic [15:0] words [2];
        words[0] = 16'h0001;
        words[1] = 16'h9999;
        for (int k = 0; k < 2; k++) begin
            imem_ack = 1'b1; imem_rdata = words[k];
            expQ.push_back({16'h0003 + 16'(k), words[k]});
            step();
            imem_ack = 1'b0;
            e = expQ.pop_front();
            checkCount++;
            if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
                $display("[TB] FAIL rf_prefetch%0d got %h want %h", k, obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
            end else passCount++;
            step();
        end
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkCount++;
            if ({imem_req, imem_addr, inst_valid} !== {1'b1, 16'h0005, 1'b0}) begin
                $display("[TB] FAIL rf_flush_hold cyc%0d got r%b a%h v%b want r1 a0005 v0", i, imem_req, imem_addr, inst_valid);
            end else passCount++;
            if (i == 0) step();
        end
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        step();
        imem_ack = 1'b0;
        checkCount++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
            $display("[TB] FAIL rf_target got v%b r%b a%h want v0 r1 a0040", inst_valid, imem_req, imem_addr);
        end else passCount++;
    endtask

    task automatic test_redirect_ack_hold();
        logic [31:0] e;
        redirect = 1'b1; redirect_pc = 16'h0100;
        imem_ack = 1'b1; imem_rdata = 16'h0008;
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        checkCount++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0100}) begin
            $display("[TB] FAIL ra_same_cycle got v%b r%b a%h want v0 r1 a0100", inst_valid, imem_req, imem_addr);
        end else passCount++;
        inst_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        expQ.push_back({16'h0100, 16'h1234});
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
            $display("[TB] FAIL ra_fetch got %h want %h", obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
        end else passCount++;
        redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect = 1'b0; inst_ready = 1'b1;
        checkCount++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0200}) begin
            $display("[TB] FAIL ra_hold_redirect got v%b r%b a%h want v0 r1 a0200", inst_valid, imem_req, imem_addr);
        end else passCount++;
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] e;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        step();
        redirect = 1'b0;
        imem_rdata = 16'h000F;
        expQ.push_back({16'hFFFF, 16'h000F});
        checkCount++;
        if ({inst_valid, imem_addr} !== {1'b0, 16'hFFFF}) begin
            $display("[TB] FAIL wrap_addr got v%b a%h want v0 aFFFF", inst_valid, imem_addr);
        end else passCount++;
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
            $display("[TB] FAIL wrap_call got %h want %h", obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
        end else passCount++;
        step();
        checkCount++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            $display("[TB] FAIL wrap_next got r%b a%h want r1 a0000", imem_req, imem_addr);
        end else passCount++;
        redirect = 1'b1; redirect_pc = 16'h0ABC;
        step();
        redirect = 1'b0;
        rst = 1'b1;
        #1;
        checkCount++;
        if (imem_req !== 1'b0) begin
            $display("[TB] FAIL rst_drop_req got r%b want r0", imem_req);
        end else passCount++;
        step();
        checkCount++;
        if ({imem_req, obsVec()} !== 38'h0) begin
            $display("[TB] FAIL rst_midflush got %h want 0", {imem_req, obsVec()});
        end else passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC_TB}) begin
            $display("[TB] FAIL rst_refetch_addr got r%b a%h want r1 a%h", imem_req, imem_addr, RESET_PC_TB);
        end else passCount++;
        imem_ack = 1'b1; imem_rdata = 16'h0ABD;
        expQ.push_back({RESET_PC_TB, 16'h0ABD});
        step();
        imem_ack = 1'b0;
        e = expQ.pop_front();
        checkCount++;
        if (obsVec() !== {1'b1, e[31:16], e[15:0], expFlags(e[3:0])}) begin
            $display("[TB] FAIL rst_refetch got %h want %h", obsVec(), {1'b1, e[31:16], e[15:0], expFlags(e[3:0])});
        end else passCount++;
    endtask

    // Run all scenarios in order, each starting where the previous left off
    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_backpressure();
        test_redirect_fetch();
        test_redirect_ack_hold();
        test_wrap_and_reset();
        checkCount++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL scoreboard_leftover got %0d want 0", expQ.size());
        end else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
